dma_copy_controller: RTL
========================

DMA_COPY_CONTROLLER -- requirements
Module: dma_copy_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bus data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, transfer length counter width in words.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: i_clk  input  1  clock; i_rst_n  input  1  async active-low reset.
REQ-005 SHALL have i_go  input  1  start pulse, sampled only in IDLE.
REQ-006 SHALL have i_abort  input  1  stop request, honoured at the next word boundary.
REQ-007 SHALL have i_src_addr  input  ADDR_WIDTH  source byte address.
REQ-008 SHALL have i_dst_addr  input  ADDR_WIDTH  destination byte address.
REQ-009 SHALL have i_len  input  LEN_WIDTH  number of words to copy.
REQ-010 SHALL have o_busy  output  1  high in every state except IDLE.
REQ-011 SHALL have o_done  output  1  one-cycle completion pulse.
REQ-012 SHALL have o_err  output  1  sticky bus error flag.
REQ-013 SHALL have o_words_done  output  LEN_WIDTH  count of words fully written.
REQ-014 SHALL have agent-side ports: o_agt_start  output  1; o_agt_we  output  1; o_agt_addr  output  ADDR_WIDTH; o_agt_wdata  output  DATA_WIDTH; i_agt_busy  input  1; i_agt_done  input  1; i_agt_rdata  input  DATA_WIDTH; i_agt_err  input  1 (qualified by i_agt_done).

Function
REQ-015 SHALL implement the states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT and DONE.
REQ-016 IDLE: on i_go with i_len!=0, SHALL latch src, dst and len, clear o_err and o_words_done, and go to RD_REQ; on i_go with i_len==0, SHALL clear o_err and go to DONE with no bus traffic.
REQ-017 RD_REQ/WR_REQ: SHALL assert o_agt_start for exactly one cycle when i_agt_busy==0, then move to the matching _WAIT state; while i_agt_busy==1, SHALL hold start low and stay.
REQ-018 o_agt_we, o_agt_addr and o_agt_wdata SHALL be registered and held stable from the start cycle through the i_agt_done cycle: we=0 with the current src address in the read phase; we=1 with the current dst address and the captured data in the write phase.
REQ-019 RD_WAIT: on i_agt_done with !i_agt_err, SHALL capture i_agt_rdata into the data register and go to WR_REQ.
REQ-020 WR_WAIT: on i_agt_done with !i_agt_err, SHALL increment o_words_done, add DATA_WIDTH/8 to src and dst, and decrement the remaining count.
REQ-021 After a successful write, SHALL go to DONE if the remaining count is 0 or i_abort has been seen; otherwise SHALL go to RD_REQ.
REQ-022 On i_agt_done with i_agt_err in either _WAIT state, SHALL set o_err, skip the write phase, and go to DONE.
REQ-023 SHALL latch i_abort in any non-IDLE state; it SHALL never cut an in-flight agent transaction, and an abort latched during a read SHALL still let that word's write complete.
REQ-024 DONE: SHALL assert o_done for one cycle, clear the abort latch, and return to IDLE.
REQ-025 i_go outside IDLE SHALL be ignored.
REQ-026 Address increments SHALL wrap modulo 2^ADDR_WIDTH.
REQ-027 i_len SHALL be treated as unsigned; the maximum value 2^LEN_WIDTH-1 SHALL be legal.
REQ-028 Timing with a zero-wait-state slave: go sampled at cycle 0 gives RD_REQ at cycle 1 and six cycles per word; o_done SHALL be high at cycle 6N+1 for N words.

Reset
REQ-029 While i_rst_n is low, SHALL asynchronously force state IDLE and drive o_busy=0, o_done=0, o_err=0, o_words_done=0, o_agt_start=0, o_agt_we=0, o_agt_addr=0 and o_agt_wdata=0.
REQ-030 Reset mid-transfer SHALL discard all progress; no resume.

Structure
REQ-031 SHALL take the state enum type and the BYTES_PER_WORD constant from the shared package dma_pkg.
REQ-032 SHALL contain no sub-module; wishbone_master_agent SHALL be a sibling instance in the DMA top, connected to the o_agt_*/i_agt_* ports.

Verification
REQ-033 src=0x1000, dst=0x2000, len=4, zero-wait slave -> reads at 0x1000, 0x1004, 0x1008 and 0x100C, each followed by its write at 0x2000+; o_done at cycle 25; o_words_done=4; o_err=0.
REQ-034 len=0 with go -> o_done pulse at cycle 1; o_agt_start never asserted; o_busy high for one cycle.
REQ-035 len=3, slave raises err on the second read -> exactly one write issued; o_err=1; o_words_done=1; o_done pulse; o_err clears on the next go.
REQ-036 len=8, abort pulsed during the 3rd read -> the 3rd write completes; o_words_done=3; o_done pulse; no 4th read.
REQ-037 src=0xFFFFFFFC, len=2 -> second read at 0x00000000.
REQ-038 Reset asserted during WR_WAIT -> all outputs at reset values immediately; a subsequent go starts cleanly.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA copy engine.
//   dma_state_t    : controller state encoding
//   BYTES_PER_WORD : byte stride of one word on the default 32-bit bus
//   bytes_per_word : byte stride for an arbitrary bus width (multiple of 8)
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DONE
  } dma_state_t;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned BYTES_PER_WORD     = bytes_per_word(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/dma_copy_controller.sv
// Word-by-word memory copy controller driving a single-transaction bus agent.
// Each word is read from src, then written to dst; addresses advance by one
// word and wrap at the top of the address space.
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_go                      : start pulse (sampled in IDLE only)
//   i_abort                   : stop after the word currently being copied
//   i_src_addr/i_dst_addr     : byte start addresses
//   i_len                     : number of words (0 completes immediately)
//   o_busy/o_done/o_err       : not idle / one-cycle completion / sticky bus error
//   o_words_done              : words fully written in the current transfer
//   o_agt_*/i_agt_*           : request/response handshake to the bus agent
module dma_copy_controller
  import dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_go,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_src_addr,
  input  logic [ADDR_WIDTH-1:0] i_dst_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [LEN_WIDTH-1:0]  o_words_done,
  output logic                  o_agt_start,
  output logic                  o_agt_we,
  output logic [ADDR_WIDTH-1:0] o_agt_addr,
  output logic [DATA_WIDTH-1:0] o_agt_wdata,
  input  logic                  i_agt_busy,
  input  logic                  i_agt_done,
  input  logic [DATA_WIDTH-1:0] i_agt_rdata,
  input  logic                  i_agt_err
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(bytes_per_word(DATA_WIDTH));

  dma_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d, words_q, words_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d, abort_q, abort_d;
  logic                  start_q, start_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      remain_q <= '0;
      words_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
      start_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      remain_q <= remain_d;
      words_q  <= words_d;
      data_q   <= data_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
      start_q  <= start_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    remain_d = remain_q;
    words_d  = words_q;
    data_d   = data_q;
    err_d    = err_q;
    start_d  = 1'b0;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    // Abort is only remembered here; it takes effect after the current write.
    abort_d  = abort_q | ((state_q != ST_IDLE) && i_abort);

    unique case (state_q)
      ST_IDLE: begin
        if (i_go) begin
          err_d = 1'b0;
          if (i_len != '0) begin
            src_d    = i_src_addr;
            dst_d    = i_dst_addr;
            remain_d = i_len;
            words_d  = '0;
            state_d  = ST_RD_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      // Request fields are registered together with start and held until
      // the next request, so they stay stable through the agent's done cycle.
      ST_RD_REQ: begin
        if (!i_agt_busy) begin
          start_d = 1'b1;
          we_d    = 1'b0;
          addr_d  = src_q;
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (i_agt_done) begin
          if (i_agt_err) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            data_d  = i_agt_rdata;
            state_d = ST_WR_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        if (!i_agt_busy) begin
          start_d = 1'b1;
          we_d    = 1'b1;
          addr_d  = dst_q;
          wdata_d = data_q;
          state_d = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (i_agt_done) begin
          if (i_agt_err) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            words_d  = words_q + LEN_WIDTH'(1);
            src_d    = src_q + ADDR_STEP;
            dst_d    = dst_q + ADDR_STEP;
            remain_d = remain_q - LEN_WIDTH'(1);
            if (remain_q == LEN_WIDTH'(1) || abort_q || i_abort)
              state_d = ST_DONE;
            else
              state_d = ST_RD_REQ;
          end
        end
      end
      ST_DONE: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_DONE);
  assign o_err        = err_q;
  assign o_words_done = words_q;
  assign o_agt_start  = start_q;
  assign o_agt_we     = we_q;
  assign o_agt_addr   = addr_q;
  assign o_agt_wdata  = wdata_q;

endmodule
